x4_state_sequencer: RTL and testbench
=====================================

// Module: x4_state_sequencer
// PURPOSE
//   Registered sequencing stage downstream of the x4 combinational control logic.
//   Buffers DEPTH data words from a host and applies ROUNDS full rotation passes.
//   Each pass XORs every word with the pass index, mirroring x4's counter/shift chain.
//   Drains the result through a valid/ready port. Exposes its step counter and
//   phase counter as current-state inputs to x4.
// PARAMETERS
//   DW      8   data word width (bits)
//   DEPTH   16  shift-bank stages; legal range 2..32
//   ROUNDS  4   rotation passes in RUN; legal range 1..8
//   CW      5   step counter width; CW >= $clog2(DEPTH)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   abort      in   1      synchronous abort: return to IDLE
//   in_valid   in   1      host word valid
//   in_ready   out  1      stage accepts a word
//   in_data    in   DW     host word
//   out_valid  out  1      drained word valid
//   out_ready  in   1      consumer accepts the word
//   out_data   out  DW     drained word (always sr[0])
//   step_cnt   out  CW     step counter (state to x4)
//   phase      out  3      current rotation pass (state to x4)
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle pulse after the last drained word
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; step_cnt=0; phase=0; done=0; sr[*]=0.
//   - Outputs: in_ready=1, out_valid=0, busy=0.
// - Shift bank sr[0..DEPTH-1]. A "shift" moves sr[i+1] into sr[i] and writes a new tail sr[DEPTH-1].
// - IDLE: in_ready=1.
//   - On accept (in_valid & in_ready): tail<=in_data, step_cnt<=1, go to LOAD.
//   - DEPTH=... the first accept counts as word 0.
// - LOAD: in_ready=1. Each accept shifts in_data into the tail and increments step_cnt.
//   - The accept that brings the count to DEPTH goes to RUN, with step_cnt<=0 and phase<=0.
//   - After LOAD, sr[0] holds the first word accepted.
// - RUN: in_ready=0, out_valid=0. Every cycle:
//   - Shift with tail <= sr[0] ^ zero-extended phase; step_cnt++.
//   - At step_cnt==DEPTH-1: step_cnt<=0, phase++.
//   - If phase==ROUNDS-1 at that wrap, go to DRAIN instead (phase held, step_cnt<=0).
//   - RUN lasts exactly DEPTH*ROUNDS cycles.
// - DRAIN: out_valid=1.
//   - On out_valid & out_ready: shift with tail<=0, step_cnt++.
//   - The DEPTH-th transfer goes to IDLE: done=1 for that next cycle, step_cnt<=0, phase<=0.
//   - Stalls (out_ready=0) hold all state, and out_data stays stable.
// - Latency: with the last LOAD accept at edge T, out_valid rises after edge T+DEPTH*ROUNDS.
// - in_valid during RUN/DRAIN is ignored; no data is lost, because in_ready=0.
// - abort=1 (any state, takes priority over handshakes):
//   - Next state IDLE; step_cnt=0; phase=0; done=0.
//   - sr contents are left unchanged.
//   - A transfer presented in the same cycle does NOT complete.
// - Reset asserted mid-operation clears everything immediately.
// - Counters never exceed DEPTH-1 (step) or ROUNDS-1 (phase); there is no wrap outside these rules.
// - All outputs are registered or decoded from registered state only. No combinational in->out paths.
// STRUCTURE
// - Package x4_seq_pkg holds:
//   - typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} x4_seq_state_t;
//   - localparam PHASE_W = 3.
// - One sub-module, x4_shift_bank (DW, DEPTH): shift enable plus tail input, full-array read.
// - FSM and counters live in x4_state_sequencer.
// TESTING (DW=8, DEPTH=4, ROUNDS=2 unless noted)
// - T1 basic: load 01,02,03,04 back-to-back.
//   -> RUN 8 cycles, phase 0 then 1.
//   -> out_data sequence 00,03,02,05; then one done pulse, busy=0.
// - T2 backpressure: repeat T1 with out_ready toggling 1,0,0,1,...
//   -> same 4 words, each held stable while stalled; done only after the 4th transfer.
// - T3 gapped load: in_valid gaps of 3 cycles between words.
//   -> step_cnt steps 1,2,3 in LOAD; RUN starts only after the 4th accept; output as T1.
// - T4 abort: assert abort at the 3rd RUN cycle.
//   -> next cycle IDLE, step_cnt=0, phase=0, in_ready=1, out_valid=0, no done.
// - T5 async reset: drop rst_n during DRAIN after 2 transfers.
//   -> out_valid=0 immediately; after release, IDLE with sr all 00.
// - T6 ROUNDS=1, DEPTH=2: load AA,55.
//   -> 2 RUN cycles, then out 55... no: out AA,55 (XOR 0); latency DEPTH*ROUNDS=2 cycles.

Source files
------------

// File: rtl/x4_seq_pkg.sv
// Shared types and constants for the x4 state sequencer.
//   x4_seq_state_t : sequencer FSM states
//   PHASE_W        : width of the rotation-pass counter exported to x4
package x4_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} x4_seq_state_t;

  localparam int unsigned PHASE_W = 3;

endpackage

// File: rtl/x4_state_sequencer_if.sv
// Host-side load port and consumer-side drain port of the x4 state sequencer.
//   in_valid/in_ready/in_data    : host words into the shift bank
//   out_valid/out_ready/out_data : drained words to the consumer
//   master : the host/consumer side; slave : the sequencer
interface x4_state_sequencer_if #(
  parameter int unsigned DW = 8
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/x4_shift_bank.sv
// DEPTH-stage shift register of DW-bit words.
//   clk, rst_n : clock, async active-low reset (clears every stage)
//   shift_en   : move sr[i+1] into sr[i] and load tail_in into sr[DEPTH-1]
//   tail_in    : new tail word
//   sr         : full array read, sr[0] is the head
module x4_shift_bank #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic [DW-1:0]              tail_in,
  output logic [DEPTH-1:0][DW-1:0]   sr
);

  logic [DEPTH-1:0][DW-1:0] sr_q;
  logic [DEPTH-1:0][DW-1:0] sr_d;

  // Next bank contents: hold, or shift toward the head with a new tail.
  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      sr_d = {tail_in, sr_q[DEPTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr = sr_q;

endmodule

// File: rtl/x4_state_sequencer.sv
// Registered sequencing stage downstream of the x4 control logic: loads DEPTH
// host words, applies ROUNDS rotation passes (each word XORed with the pass
// index), then drains the words through a valid/ready port.
//   clk, rst_n : clock, async active-low reset
//   abort      : synchronous return to IDLE, beats any handshake
//   bus        : load port (in_*) and drain port (out_*), slave side
//   step_cnt   : step counter exported to x4
//   phase      : current rotation pass exported to x4
//   busy       : sequencer is not IDLE
//   done       : one-cycle pulse after the last drained word
module x4_state_sequencer
  import x4_seq_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned CW     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 abort,
  x4_state_sequencer_if.slave  bus,
  output logic [CW-1:0]        step_cnt,
  output logic [PHASE_W-1:0]   phase,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CW-1:0]      STEP_LAST  = CW'(DEPTH - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(ROUNDS - 1);

  x4_seq_state_t        state_q, state_d;
  logic [CW-1:0]        step_q, step_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic                 done_q, done_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic                      shift_en;
  logic [DW-1:0]             tail;
  logic [DEPTH-1:0][DW-1:0]  sr;
  logic                      accept;
  logic                      xfer;
  logic                      sr_upper_unused;

  // Handshakes qualified by the registered ready/valid the other side sees.
  assign accept = bus.in_valid  & in_ready_q;
  assign xfer   = bus.out_ready & out_valid_q;

  x4_shift_bank #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .tail_in  (tail),
    .sr       (sr)
  );

  // Only the head is observed here; the rest of the bank recirculates internally.
  assign sr_upper_unused = ^sr[DEPTH-1:1];

  // State register, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      phase_q     <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      phase_q     <= phase_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      step_d  = '0;
      phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = LOAD;
            step_d  = CW'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            if (step_q == STEP_LAST) begin
              state_d = RUN;
              step_d  = '0;
              phase_d = '0;
            end else begin
              step_d = step_q + CW'(1);
            end
          end
        end
        RUN: begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            // Last pass finished: phase stays at ROUNDS-1 through DRAIN.
            if (phase_q == PHASE_LAST) begin
              state_d = DRAIN;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
            end
          end else begin
            step_d = step_q + CW'(1);
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (step_q == STEP_LAST) begin
              state_d = IDLE;
              step_d  = '0;
              phase_d = '0;
              done_d  = 1'b1;
            end else begin
              step_d = step_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bank control and next values of the registered port outputs.
  always_comb begin
    shift_en    = 1'b0;
    tail        = '0;
    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != IDLE);
    if (!abort) begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept) begin
            shift_en = 1'b1;
            tail     = bus.in_data;
          end
        end
        RUN: begin
          shift_en = 1'b1;
          tail     = sr[0] ^ DW'(phase_q);
        end
        DRAIN: begin
          shift_en = xfer;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = sr[0];
  assign step_cnt      = step_q;
  assign phase         = phase_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_x4_state_sequencer.sv
// Bench for x4_state_sequencer: DUT A (DEPTH=4, ROUNDS=2) is tracked by a
// position-based model every cycle; DUT B (DEPTH=2, ROUNDS=1) covers the
// single-pass case with literal expectations.
module tb_x4_state_sequencer;
  import x4_seq_pkg::*;

  localparam int DW = 8;
  localparam int CW = 5;
  localparam int DA = 4;
  localparam int RA = 2;
  localparam int DB = 2;
  localparam int RB = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;

  always #5 clk = ~clk;

  x4_state_sequencer_if #(.DW(DW)) bus_a ();
  x4_state_sequencer_if #(.DW(DW)) bus_b ();

  logic [CW-1:0]      step_a, step_b;
  logic [PHASE_W-1:0] phase_a, phase_b;
  logic               busy_a, busy_b, done_a, done_b;

  x4_state_sequencer #(.DW(DW), .DEPTH(DA), .ROUNDS(RA), .CW(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .abort(abort_a), .bus(bus_a),
    .step_cnt(step_a), .phase(phase_a), .busy(busy_a), .done(done_a)
  );

  x4_state_sequencer #(.DW(DW), .DEPTH(DB), .ROUNDS(RB), .CW(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .abort(abort_b), .bus(bus_b),
    .step_cnt(step_b), .phase(phase_b), .busy(busy_b), .done(done_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of DUT A: bank contents plus job position (words loaded, run cycles, words drained).
  logic [DW-1:0] bank [DA];
  int  m_in   = 0;
  int  m_run  = 0;
  int  m_out  = 0;
  bit  m_done = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DA; i++) bank[i] <= '0;
      m_in   <= 0;
      m_run  <= 0;
      m_out  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (abort_a) begin
        m_in  <= 0;
        m_run <= 0;
        m_out <= 0;
      end else if (m_in < DA) begin
        if (bus_a.in_valid) begin
          for (int i = 0; i < DA - 1; i++) bank[i] <= bank[i+1];
          bank[DA-1] <= bus_a.in_data;
          m_in  <= m_in + 1;
          m_run <= 0;
          m_out <= 0;
        end
      end else if (m_run < DA * RA) begin
        for (int i = 0; i < DA - 1; i++) bank[i] <= bank[i+1];
        bank[DA-1] <= bank[0] ^ DW'(m_run / DA);
        m_run <= m_run + 1;
      end else if (bus_a.out_ready) begin
        for (int i = 0; i < DA - 1; i++) bank[i] <= bank[i+1];
        bank[DA-1] <= '0;
        if (m_out == DA - 1) begin
          m_done <= 1'b1;
          m_in   <= 0;
          m_run  <= 0;
          m_out  <= 0;
        end else begin
          m_out <= m_out + 1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT A against the model.
  always @(negedge clk) begin
    check("mdl_in_ready", 32'(bus_a.in_ready), (m_in < DA) ? 1 : 0);
    check("mdl_out_valid", 32'(bus_a.out_valid), (m_in == DA && m_run == DA * RA) ? 1 : 0);
    check("mdl_busy", 32'(busy_a), (m_in > 0) ? 1 : 0);
    check("mdl_done", 32'(done_a), 32'(m_done));
    check("mdl_step_cnt", 32'(step_a),
          (m_in < DA) ? m_in : ((m_run < DA * RA) ? (m_run % DA) : m_out));
    check("mdl_phase", 32'(phase_a),
          (m_in < DA) ? 0 : ((m_run < DA * RA) ? (m_run / DA) : (RA - 1)));
    check("mdl_out_data", 32'(bus_a.out_data), 32'(bank[0]));
  end

  logic [DW-1:0] got [$];
  logic [DW-1:0] exp_t1 [DA];
  logic [DW-1:0] exp_t6 [DB];

  task automatic load_a(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                        input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                        input int gap, input bit chk_step);
    logic [DW-1:0] w [DA];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < DA; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = w[i];
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      if (i < DA - 1) begin
        if (chk_step) check($sformatf("T3_step_after_word%0d", i), 32'(step_a), i + 1);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (chk_step) check($sformatf("T3_step_hold_word%0d", i), 32'(step_a), i + 1);
        end
      end
    end
  endtask

  task automatic wait_out_a(output int lat);
    lat = 0;
    while (bus_a.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Drain n words from DUT A; bp selects the 1,0,0,1 ready pattern.
  task automatic drain_a(input int n, input bit bp);
    int k = 0;
    logic [DW-1:0] d;
    logic v;
    got.delete();
    while (got.size() < n && k < 100) begin
      bus_a.out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      d = bus_a.out_data;
      v = bus_a.out_valid;
      @(negedge clk);
      if (v && bus_a.out_ready) got.push_back(d);
      k++;
    end
    bus_a.out_ready = 1'b0;
    check("drain_count", 32'(got.size()), n);
  endtask

  task automatic full_job_a(input string tag, input bit bp);
    int lat;
    load_a(8'h01, 8'h02, 8'h03, 8'h04, 0, 1'b0);
    wait_out_a(lat);
    check({tag, "_latency"}, 32'(lat), DA * RA);
    drain_a(DA, bp);
    for (int i = 0; i < got.size(); i++) check($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp_t1[i]));
    check({tag, "_done_pulse"}, 32'(done_a), 1);
    check({tag, "_busy_end"}, 32'(busy_a), 0);
    @(negedge clk);
    check({tag, "_done_cleared"}, 32'(done_a), 0);
  endtask

  initial begin
    int lat;
    exp_t1[0] = 8'h00; exp_t1[1] = 8'h03; exp_t1[2] = 8'h02; exp_t1[3] = 8'h05;
    exp_t6[0] = 8'hAA; exp_t6[1] = 8'h55;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus_a.in_ready), 1);
    check("rst_out_valid", 32'(bus_a.out_valid), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_step", 32'(step_a), 0);
    check("rst_out_data", 32'(bus_a.out_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 basic, T2 backpressure
    full_job_a("T1", 1'b0);
    full_job_a("T2", 1'b1);

    // T3 gapped load; in_valid held high during RUN must be ignored
    load_a(8'h01, 8'h02, 8'h03, 8'h04, 3, 1'b1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'hEE;
    wait_out_a(lat);
    bus_a.in_valid = 1'b0;
    check("T3_latency", 32'(lat), DA * RA);
    drain_a(DA, 1'b0);
    for (int i = 0; i < got.size(); i++) check($sformatf("T3_word%0d", i), 32'(got[i]), 32'(exp_t1[i]));
    @(negedge clk);

    // T4 abort during the 3rd RUN cycle
    load_a(8'h01, 8'h02, 8'h03, 8'h04, 0, 1'b0);
    repeat (2) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("T4_busy", 32'(busy_a), 0);
    check("T4_step", 32'(step_a), 0);
    check("T4_phase", 32'(phase_a), 0);
    check("T4_in_ready", 32'(bus_a.in_ready), 1);
    check("T4_out_valid", 32'(bus_a.out_valid), 0);
    check("T4_sr_kept", 32'(bus_a.out_data), 32'h03);
    @(negedge clk);
    check("T4_no_done", 32'(done_a), 0);

    // T5 async reset in DRAIN after two transfers
    load_a(8'h01, 8'h02, 8'h03, 8'h04, 0, 1'b0);
    wait_out_a(lat);
    drain_a(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("T5_out_valid_async", 32'(bus_a.out_valid), 0);
    check("T5_busy_async", 32'(busy_a), 0);
    check("T5_step_async", 32'(step_a), 0);
    check("T5_out_data_async", 32'(bus_a.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("T5_idle_in_ready", 32'(bus_a.in_ready), 1);
    check("T5_idle_sr0", 32'(bus_a.out_data), 0);

    // T6 single pass, DEPTH=2, on DUT B
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = 8'hAA;
    @(negedge clk);
    check("T6_step_load", 32'(step_b), 1);
    bus_b.in_data  = 8'h55;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    check("T6_run_busy", 32'(busy_b), 1);
    check("T6_run_in_ready", 32'(bus_b.in_ready), 0);
    lat = 0;
    while (bus_b.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("T6_latency", 32'(lat), DB * RB);
    check("T6_phase", 32'(phase_b), 0);
    got.delete();
    bus_b.out_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < DB; k++) begin
      logic [DW-1:0] d;
      logic v;
      d = bus_b.out_data;
      v = bus_b.out_valid;
      @(negedge clk);
      if (v) got.push_back(d);
    end
    bus_b.out_ready = 1'b0;
    check("T6_count", 32'(got.size()), DB);
    for (int i = 0; i < got.size(); i++) check($sformatf("T6_word%0d", i), 32'(got[i]), 32'(exp_t6[i]));
    check("T6_done", 32'(done_b), 1);
    check("T6_busy_end", 32'(busy_b), 0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
